nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract engine: one shared 4-bit ripple-carry slice
// processes one nibble per clock, LSB first, with a registered carry between nibbles.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [3:0] add_a, add_b, add_s;
    logic       add_co;

    assign add_a = a_q[4*k_q +: 4];
    assign add_b = b_q[4*k_q +: 4];

    ripple_carry_adder u_slice (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is folded into the operand latch: A + ~B + 1.
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    sum_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*k_q +: 4] = add_s;
                carry_d           = add_co;
                k_d               = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // Carry into the MSB is recovered from its sum bit and operands.
                    cout_d  = add_co;
                    ovf_d   = (add_a[3] ^ add_b[3] ^ add_s[3]) ^ add_co;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16): vector table plus
// hand-written backpressure and mid-operation reset sequences.

module tb_nibble_serial_adder_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents operands for exactly one edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~cin; Sub = ~sub;
    endtask

    // Called #1 after the acceptance edge; checks latency and the result.
    task automatic wait_result(input string name, input logic [W-1:0] es,
                               input logic ec, input logic eo);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk({name, "_busy"}, busy, 1);
        end
        chk({name, "_latency"}, lat, N);
        chk({name, "_sum"}, Sum, es);
        chk({name, "_cout"}, Cout, ec);
        chk({name, "_ovf"}, Ovf, eo);
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_in_ready_after"}, in_ready, 1);
        chk({name, "_out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[7] = '{16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset values, asserted before any clock edge.
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_ovf", Ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_result($sformatf("v%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            release_result($sformatf("v%0d", i));
            $display("vec %0d: A=%h B=%h Cin=%b Sub=%b -> Sum=%h Cout=%b Ovf=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, Sum, Cout, Ovf);
        end

        // Result held under backpressure while new requests are refused.
        out_ready = 1'b0;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("bp", 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; Sub = 1'b0;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            chk($sformatf("bp%0d_sum", i), Sum, 16'h5555);
            chk($sformatf("bp%0d_cout_ovf", i), {Cout, Ovf}, 2'b00);
        end
        in_valid = 1'b0;
        release_result("bp");
        chk("bp_sum_held_idle", Sum, 16'h5555);
        $display("backpressure: held Sum=%h for 5 cycles, released", Sum);
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        wait_result("bp_next", 16'h1000, 1'b0, 1'b0);
        release_result("bp_next");

        // Flags left at Cout=1/Ovf=1 so the reset clear is observable.
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result("pre_rst", 16'h0000, 1'b1, 1'b1);
        release_result("pre_rst");

        // Asynchronous reset after two of four nibbles.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", Sum, 0);
        chk("mid_rst_cout", Cout, 0);
        chk("mid_rst_ovf", Ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk("mid_rst_no_out_valid", hits, 0);
        $display("mid-run reset: aborted operation discarded");
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_result("post_rst", 16'h0100, 1'b0, 1'b0);
        release_result("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
